// File: rtl/gvp_pkg.sv
// rtl/gvp_pkg.sv - shared store kinds, FSM states and vector record for gvp_nax
package gvp_pkg;

    localparam logic [1:0] ST_KIND_POINT  = 2'd1;
    localparam logic [1:0] ST_KIND_HEADER = 2'd2;
    localparam logic [1:0] ST_KIND_END    = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_STEP,
        S_DONE
    } gvp_state_t;

    // Fixed-width vector fields; deltas and jump offsets are parameter-sized and live alongside.
    typedef struct packed {
        logic [31:0] n;
        logic [31:0] nii;
        logic [31:0] deci;
        logic [31:0] nrep;
        logic [31:0] opt;
    } gvp_vec_t;

endpackage

// File: rtl/gvp_axis_acc.sv
// rtl/gvp_axis_acc.sv - one axis position accumulator
// Define GVP_NAX_SAT_EN to saturate at the signed limits instead of wrapping.
module gvp_axis_acc #(
    parameter int DATA_W = 32
) (
    input  logic              a_clk,
    input  logic              a_resetn,
    input  logic              step,
    input  logic [DATA_W-1:0] delta,
    output logic [DATA_W-1:0] pos
);

    logic [DATA_W-1:0] sum;
    logic [DATA_W-1:0] pos_nxt;

    assign sum = pos + delta;

`ifdef GVP_NAX_SAT_EN
    logic ovf;

    // Overflow only when both operands share a sign and the result flips it.
    assign ovf     = (pos[DATA_W-1] == delta[DATA_W-1]) && (sum[DATA_W-1] != pos[DATA_W-1]);
    assign pos_nxt = !ovf          ? sum :
                     pos[DATA_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} :
                                     {1'b0, {(DATA_W-1){1'b1}}};
`else
    assign pos_nxt = sum;
`endif

    always_ff @(posedge a_clk or negedge a_resetn) begin
        if (!a_resetn) begin
            pos <= '0;
        end else if (step) begin
            pos <= pos_nxt;
        end
    end

endmodule

// File: rtl/gvp_nax.sv
// rtl/gvp_nax.sv - multi-axis vector program sequencer with store-event stream
// Optional saturating position arithmetic: define GVP_NAX_SAT_EN.
module gvp_nax
    import gvp_pkg::*;
#(
    parameter int NUM_AXES       = 6,
    parameter int NUM_VECTORS_N2 = 5,
    parameter int DATA_W         = 32
) (
    input  logic                         a_clk,
    input  logic                         a_resetn,
    input  logic                         start,
    input  logic                         pause,
    input  logic                         abort,
    input  logic                         wr_en,
    input  logic [NUM_VECTORS_N2-1:0]    wr_adr,
    input  logic [31:0]                  wr_n,
    input  logic [31:0]                  wr_nii,
    input  logic [31:0]                  wr_deci,
    input  logic [31:0]                  wr_nrep,
    input  logic [NUM_VECTORS_N2:0]      wr_next,
    input  logic [31:0]                  wr_opt,
    input  logic [NUM_AXES*DATA_W-1:0]   wr_d,
    output logic [NUM_AXES*DATA_W-1:0]   pos_tdata,
    output logic [31:0]                  opt_out,
    output logic                         st_tvalid,
    input  logic                         st_tready,
    output logic [1:0]                   st_tkind,
    output logic [31:0]                  st_index,
    output logic [47:0]                  gvp_time,
    output logic                         busy,
    output logic                         finished,
    output logic                         err,
    output logic                         wr_rej
);

    localparam int NV = 1 << NUM_VECTORS_N2;
    localparam int PW = NUM_VECTORS_N2;
    localparam int AW = NUM_AXES * DATA_W;

    // Program memory is deliberately not reset so a program survives a_resetn.
    gvp_vec_t      prog_mem [NV];
    logic [PW:0]   next_mem [NV];
    logic [AW-1:0] d_mem    [NV];
    logic [31:0]   loop_cnt [NV];

    gvp_state_t    state;
    logic [PW-1:0] pvc;
    logic [31:0]   i_cnt;
    logic [31:0]   ii_cnt;
    logic [31:0]   dcnt;

    gvp_vec_t      cur;
    logic [AW-1:0] cur_d;
    logic [PW:0]   cur_next;
    logic [31:0]   cur_loop;
    logic          wr_ok;
    logic          pending;
    logic          do_step;
    logic          sec_end;
    logic          take_jump;
    logic [PW:0]   pvc_ofs;
    logic [PW+1:0] pvc_new;
    logic          pvc_bad;

    assign cur      = prog_mem[pvc];
    assign cur_d    = d_mem[pvc];
    assign cur_next = next_mem[pvc];
    assign cur_loop = loop_cnt[pvc];

    assign wr_ok     = wr_en && (state == S_IDLE || state == S_DONE);
    assign pending   = st_tvalid && !st_tready;
    assign do_step   = (state == S_STEP) && !abort && !pause && (dcnt == 32'd0) && !pending;
    assign sec_end   = do_step && (ii_cnt == 32'd0) && (i_cnt == 32'd0);
    assign take_jump = (cur_loop != 32'd0);
    assign pvc_ofs   = take_jump ? cur_next : {{PW{1'b0}}, 1'b1};

    // Two extra bits: the top one flags a negative target, the next one a target >= NV.
    assign pvc_new = {2'b00, pvc} + {pvc_ofs[PW], pvc_ofs};
    assign pvc_bad = pvc_new[PW+1] | pvc_new[PW];

    assign busy     = (state == S_LOAD) || (state == S_STEP);
    assign finished = (state == S_DONE);

    always_ff @(posedge a_clk) begin
        if (wr_ok) begin
            prog_mem[wr_adr] <= '{n: wr_n, nii: wr_nii, deci: wr_deci, nrep: wr_nrep, opt: wr_opt};
            next_mem[wr_adr] <= wr_next;
            d_mem[wr_adr]    <= wr_d;
            loop_cnt[wr_adr] <= wr_nrep;
        end else if (sec_end) begin
            loop_cnt[pvc] <= take_jump ? cur_loop - 32'd1 : cur.nrep;
        end
    end

    genvar k;
    generate
        for (k = 0; k < NUM_AXES; k++) begin : g_axis
            gvp_axis_acc #(
                .DATA_W (DATA_W)
            ) u_acc (
                .a_clk    (a_clk),
                .a_resetn (a_resetn),
                .step     (do_step),
                .delta    (cur_d[k*DATA_W +: DATA_W]),
                .pos      (pos_tdata[k*DATA_W +: DATA_W])
            );
        end
    endgenerate

    always_ff @(posedge a_clk or negedge a_resetn) begin
        if (!a_resetn) begin
            state     <= S_IDLE;
            pvc       <= '0;
            i_cnt     <= '0;
            ii_cnt    <= '0;
            dcnt      <= '0;
            opt_out   <= '0;
            st_tvalid <= 1'b0;
            st_tkind  <= '0;
            st_index  <= '0;
            gvp_time  <= '0;
            err       <= 1'b0;
            wr_rej    <= 1'b0;
        end else begin
            wr_rej <= wr_en && (state == S_LOAD || state == S_STEP);
            if (st_tvalid && st_tready) begin
                st_tvalid <= 1'b0;
            end
            if (state == S_LOAD || state == S_STEP) begin
                gvp_time <= gvp_time + 48'd1;
            end

            if (abort) begin
                state     <= S_IDLE;
                st_tvalid <= 1'b0;
                opt_out   <= '0;
            end else begin
                case (state)
                    S_IDLE, S_DONE: begin
                        if (start) begin
                            err      <= 1'b0;
                            gvp_time <= '0;
                            pvc      <= '0;
                            state    <= S_LOAD;
                        end
                    end
                    S_LOAD: begin
                        if (!pending) begin
                            st_tvalid <= 1'b1;
                            if (cur.n == 32'd0) begin
                                st_tkind <= ST_KIND_END;
                                st_index <= '0;
                                opt_out  <= '1;
                                state    <= S_DONE;
                            end else begin
                                st_tkind <= ST_KIND_HEADER;
                                st_index <= cur.n;
                                i_cnt    <= cur.n;
                                ii_cnt   <= cur.nii;
                                dcnt     <= cur.deci;
                                opt_out  <= cur.opt;
                                state    <= S_STEP;
                            end
                        end
                    end
                    S_STEP: begin
                        if (do_step) begin
                            dcnt <= cur.deci;
                            if (ii_cnt != 32'd0) begin
                                ii_cnt <= ii_cnt - 32'd1;
                            end else if (i_cnt != 32'd0) begin
                                st_tvalid <= 1'b1;
                                st_tkind  <= ST_KIND_POINT;
                                st_index  <= i_cnt;
                                i_cnt     <= i_cnt - 32'd1;
                                ii_cnt    <= cur.nii;
                            end else if (pvc_bad) begin
                                err   <= 1'b1;
                                state <= S_DONE;
                            end else begin
                                pvc   <= pvc_new[PW-1:0];
                                state <= S_LOAD;
                            end
                        end else if (dcnt != 32'd0) begin
                            dcnt <= dcnt - 32'd1;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
